dcache_control: RTL
===================

Name: dcache_control

Overview:
Sequencing FSM for the 2-way, 8-set data cache datapath (tag/valid/dirty arrays plus line muxing). It handles CPU requests, chooses the victim way with a per-set LRU bit, and orders writeback and refill transactions on the physical-memory port. It sits between the CPU data-memory handshake and the pmem handshake, and drives the datapath's per-way load and write-type strobes.

Parameters:
NUM_SETS, 8, number of sets; equals 2**INDEX_WIDTH.
INDEX_WIDTH, 3, width of the set index, taken from address bits [6:4].
CNT_WIDTH, 16, width of each performance counter.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
mem_read  in  1  CPU read request; held until mem_resp
mem_write  in  1  CPU write request; held until mem_resp
mem_index  in  INDEX_WIDTH  set index of the current CPU address
hit  in  1  either way hits
set_one_hit  in  1  way-one tag match and valid
set_two_hit  in  1  way-two tag match and valid
set_one_valid, set_two_valid  in  1 each  valid bits of the indexed set
set_one_dirty, set_two_dirty  in  1 each  dirty bits of the indexed set
pmem_resp  in  1  physical-memory transaction complete
mem_resp  out  1  CPU request complete
load_set_one, load_set_two  out  1 each  write strobe into each way
write_type_set_one, write_type_set_two  out  1 each  0 = clean fill (dirty cleared), 1 = CPU write (dirty set)
line_sel  out  1  datapath input-line mux select: 0 = pmem_rdata, 1 = CPU-merged line
pmem_addr_sel  out  2  00 = CPU address, 01 = way-one tag+index, 10 = way-two tag+index
pmem_read, pmem_write  out  1 each  physical-memory request strobes
hit_count, miss_count  out  CNT_WIDTH each  performance counters

Behaviour:
- Reset (asynchronous): state=IDLE, LRU array all 0, victim_q=0, counters 0. All outputs 0 while rst is high.
- All strobes are Moore/Mealy combinational from state and inputs, so they drop in the same cycle that rst asserts.
- LRU bit per set: 0 means way one is least recent, 1 means way two is least recent.
- IDLE, no request: all outputs 0.
- IDLE, request and hit (read): mem_resp=1 in the same cycle, so latency is 0 cycles after the request is seen. On the clock edge, LRU[mem_index] points to the way not hit.
- IDLE, request and hit (write): mem_resp=1, load_set_x=1 for the hit way, write_type_set_x=1, line_sel=1. LRU is updated as for a read.
- mem_read and mem_write both high: treated as a write.
- set_one_hit and set_two_hit both high: illegal. Way one takes priority, and the simulation assertion fires.
- IDLE, request and miss: the victim is chosen in this order:
  1. way one if invalid;
  2. else way two if invalid;
  3. else the way named by LRU[mem_index].
  The victim is registered into victim_q and miss_count is incremented once. Next state is WRITEBACK if the victim is valid and dirty, otherwise ALLOCATE.
- hit_count increments once per completed hit response. A hit that follows a refill also counts.
- Both counters saturate at all-ones and never wrap.
- WRITEBACK: pmem_write=1 and pmem_addr_sel = 01 or 10 according to victim_q. Hold until pmem_resp, then go to ALLOCATE.
- ALLOCATE: pmem_read=1 and pmem_addr_sel=00. When pmem_resp arrives: load_set_victim=1, write_type=0, line_sel=0, then go to IDLE. The hit is re-evaluated in IDLE on the next cycle.
  - A read miss costs writeback (if any) + fill + 1 cycle.
  - A write miss then completes as a write hit in IDLE.
- Request deasserted mid-miss: the pmem transaction in flight still completes (no abort), then the FSM returns to IDLE. No mem_resp is issued for the dropped request.
- pmem_resp is ignored in IDLE.
- mem_resp is never asserted outside IDLE.
- Reset mid-WRITEBACK or mid-ALLOCATE: returns to IDLE immediately, pmem strobes drop, and no line is loaded.

Decomposition:
- The shared lc3b_types package gains:
  - lc3b_cache_index (INDEX_WIDTH bits);
  - an enum lc3b_dcache_state_t {IDLE, WRITEBACK, ALLOCATE};
  - an enum lc3b_pmem_addr_sel_t {PMEM_SEL_CPU=2'b00, PMEM_SEL_WAY1=2'b01, PMEM_SEL_WAY2=2'b10}.
- One sub-module, dcache_lru: an NUM_SETS x 1 register array with asynchronous clear, a read port on index, and a write port taking index, enable and value. The FSM and counters stay in dcache_control.

Test Plan:
- Read hit, way one: rst released; set_one_hit=1, mem_read=1, index 3 -> mem_resp=1 in the same cycle; LRU[3]=1 afterwards; hit_count=1.
- Clean miss: both ways valid, not dirty, LRU[5]=0; mem_read at index 5 -> ALLOCATE with pmem_read=1 and pmem_addr_sel=00. pmem_resp after 4 cycles -> load_set_one=1, write_type_set_one=0, line_sel=0. Next cycle, hit gives mem_resp; miss_count=1.
- Dirty miss: LRU[2]=1, way two valid and dirty; mem_write -> WRITEBACK with pmem_write=1 and pmem_addr_sel=10. On pmem_resp -> ALLOCATE, then fill way two, then a write hit with write_type_set_two=1, line_sel=1 and mem_resp=1.
- Invalid-way preference: way one valid, way two invalid, LRU=0; miss -> way two filled and no WRITEBACK visited.
- Reset mid-WRITEBACK: assert rst between clock edges -> pmem_write drops before the next edge; state=IDLE; all LRU bits 0; counters 0.
- Counter saturation: preload hit_count=16'hFFFF via force, then issue a hit -> hit_count stays 16'hFFFF.

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared lc3b types for the data cache controller
package lc3b_types;

   localparam int DCACHE_INDEX_WIDTH = 3;
   localparam int DCACHE_NUM_SETS    = 2 ** DCACHE_INDEX_WIDTH;
   localparam int DCACHE_CNT_WIDTH   = 16;

   typedef logic [DCACHE_INDEX_WIDTH-1:0] lc3b_cache_index;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WRITEBACK = 2'b01,
      ALLOCATE  = 2'b10
   } lc3b_dcache_state_t;

   typedef enum logic [1:0] {
      PMEM_SEL_CPU  = 2'b00,
      PMEM_SEL_WAY1 = 2'b01,
      PMEM_SEL_WAY2 = 2'b10
   } lc3b_pmem_addr_sel_t;

endpackage

// File: rtl/dcache_control_lru.sv
// rtl/dcache_control_lru.sv - per-set LRU bit array for the 2-way data cache
module dcache_lru #(
   parameter int NUM_SETS    = 8,
   parameter int INDEX_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INDEX_WIDTH-1:0] rd_index,
   output logic                   rd_value,
   input  logic [INDEX_WIDTH-1:0] wr_index,
   input  logic                   wr_en,
   input  logic                   wr_value
);

   // bit set = way two is least recently used in that set
   logic [NUM_SETS-1:0] lru_q;

   // update the addressed set's LRU bit; cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lru_q <= '0;
      end else if (wr_en) begin
         lru_q[wr_index] <= wr_value;
      end
   end

   assign rd_value = lru_q[rd_index];

endmodule

// File: rtl/dcache_control.sv
// rtl/dcache_control.sv - sequencing FSM for the 2-way 8-set data cache
module dcache_control
   import lc3b_types::*;
#(
   parameter int NUM_SETS    = DCACHE_NUM_SETS,
   parameter int INDEX_WIDTH = DCACHE_INDEX_WIDTH,
   parameter int CNT_WIDTH   = DCACHE_CNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [INDEX_WIDTH-1:0] mem_index,
   input  logic                   hit,
   input  logic                   set_one_hit,
   input  logic                   set_two_hit,
   input  logic                   set_one_valid,
   input  logic                   set_two_valid,
   input  logic                   set_one_dirty,
   input  logic                   set_two_dirty,
   input  logic                   pmem_resp,
   output logic                   mem_resp,
   output logic                   load_set_one,
   output logic                   load_set_two,
   output logic                   write_type_set_one,
   output logic                   write_type_set_two,
   output logic                   line_sel,
   output logic [1:0]             pmem_addr_sel,
   output logic                   pmem_read,
   output logic                   pmem_write,
   output logic [CNT_WIDTH-1:0]   hit_count,
   output logic [CNT_WIDTH-1:0]   miss_count
);

   lc3b_dcache_state_t   state_q, next_state;
   logic                 victim_q, victim_d, victim_dirty;
   logic                 lru_rd, lru_we, lru_wdata;
   logic                 hit_event, miss_event;
   logic                 req;
   logic [CNT_WIDTH-1:0] hit_count_q, miss_count_q;

   assign req = mem_read | mem_write;

   dcache_lru #(
      .NUM_SETS    (NUM_SETS),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_lru (
      .clk      (clk),
      .rst      (rst),
      .rd_index (mem_index),
      .rd_value (lru_rd),
      .wr_index (mem_index),
      .wr_en    (lru_we),
      .wr_value (lru_wdata)
   );

   // victim choice: an invalid way is free, otherwise evict the LRU way
   always_comb begin
      victim_d = lru_rd;
      if (!set_one_valid) begin
         victim_d = 1'b0;
      end else if (!set_two_valid) begin
         victim_d = 1'b1;
      end
      victim_dirty = victim_d ? (set_two_valid & set_two_dirty)
                              : (set_one_valid & set_one_dirty);
   end

   // strobes and next state; everything forced low while reset is held
   always_comb begin
      next_state         = state_q;
      mem_resp           = 1'b0;
      load_set_one       = 1'b0;
      load_set_two       = 1'b0;
      write_type_set_one = 1'b0;
      write_type_set_two = 1'b0;
      line_sel           = 1'b0;
      pmem_addr_sel      = PMEM_SEL_CPU;
      pmem_read          = 1'b0;
      pmem_write         = 1'b0;
      lru_we             = 1'b0;
      lru_wdata          = 1'b0;
      hit_event          = 1'b0;
      miss_event         = 1'b0;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               if (req && hit) begin
                  mem_resp  = 1'b1;
                  hit_event = 1'b1;
                  lru_we    = 1'b1;
                  // the way not touched becomes least recent; way one wins a double hit
                  lru_wdata = set_one_hit;
                  if (mem_write) begin
                     line_sel = 1'b1;
                     if (set_one_hit) begin
                        load_set_one       = 1'b1;
                        write_type_set_one = 1'b1;
                     end else begin
                        load_set_two       = 1'b1;
                        write_type_set_two = 1'b1;
                     end
                  end
               end else if (req) begin
                  miss_event = 1'b1;
                  next_state = victim_dirty ? WRITEBACK : ALLOCATE;
               end
            end
            WRITEBACK: begin
               pmem_write    = 1'b1;
               pmem_addr_sel = victim_q ? PMEM_SEL_WAY2 : PMEM_SEL_WAY1;
               if (pmem_resp) begin
                  next_state = ALLOCATE;
               end
            end
            ALLOCATE: begin
               pmem_read = 1'b1;
               if (pmem_resp) begin
                  // clean fill from pmem_rdata; the request replays as a hit in IDLE
                  if (victim_q) begin
                     load_set_two = 1'b1;
                  end else begin
                     load_set_one = 1'b1;
                  end
                  next_state = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // state, victim register and saturating performance counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         victim_q     <= 1'b0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         state_q <= next_state;
         if (miss_event) begin
            victim_q <= victim_d;
         end
         if (hit_event && (hit_count_q != {CNT_WIDTH{1'b1}})) begin
            hit_count_q <= hit_count_q + CNT_WIDTH'(1);
         end
         if (miss_event && (miss_count_q != {CNT_WIDTH{1'b1}})) begin
            miss_count_q <= miss_count_q + CNT_WIDTH'(1);
         end
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

   // both ways matching the same tag means the datapath is corrupt
   a_single_way_hit: assert property (@(posedge clk) disable iff (rst)
      !(state_q == IDLE && req && set_one_hit && set_two_hit));

endmodule
